// File: rtl/vector_fetch.sv
// Reset/NMI/IRQ/BRK vector fetch sequencer driving the PC load port.
// Optional mem_ready timeout (sticky fault) enabled by defining VECFETCH_TIMEOUT_EN.
module vector_fetch #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        i_flag,
  input  logic        brk_req,
  input  logic        boundary,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ready,
  input  logic [7:0]  mem_data,
  output logic [7:0]  PCL_in,
  output logic [7:0]  PCH_in,
  output logic        load_pc_l,
  output logic        load_pc_h,
  output logic        busy,
  output logic        done,
  output logic [1:0]  vector_id,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    COMMIT   = 2'd3
  } state_e;

  localparam logic [1:0]  VEC_RES  = 2'd0;
  localparam logic [1:0]  VEC_NMI  = 2'd1;
  localparam logic [1:0]  VEC_IRQ  = 2'd2;
  localparam logic [15:0] BASE_RES = 16'hFFFC;
  localparam logic [15:0] BASE_NMI = 16'hFFFA;
  localparam logic [15:0] BASE_IRQ = 16'hFFFE;

  state_e      state_q, state_d;
  logic        res_pend_q, res_pend_d;
  logic        nmi_pend_q, nmi_pend_d;
  logic        brk_pend_q, brk_pend_d;
  logic        nmi_q;
  logic [15:0] base_q, base_d;
  logic [1:0]  vid_q, vid_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  pcl_q, pcl_d;
  logic [7:0]  pch_q, pch_d;

  logic nmi_edge, nmi_eff, irq_act, fetching;

  assign nmi_edge = nmi_q & ~nmi_n;
  assign nmi_eff  = nmi_pend_q | nmi_edge;
  assign irq_act  = ~irq_n & ~i_flag;
  assign fetching = (state_q == FETCH_LO) || (state_q == FETCH_HI);

`ifdef VECFETCH_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);
  logic [7:0] wait_q, wait_d;
  logic       fault_q, fault_d;
`else
  logic unused_wait_limit;
  assign unused_wait_limit = ^WAIT_LIMIT;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin : next_state
    state_d    = state_q;
    res_pend_d = res_pend_q;
    nmi_pend_d = nmi_pend_q | nmi_edge;
    brk_pend_d = brk_pend_q | brk_req;
    base_d     = base_q;
    vid_d      = vid_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    pcl_d      = pcl_q;
    pch_d      = pch_q;

    unique case (state_q)
      IDLE: begin
        if (res_pend_q) begin
          state_d    = FETCH_LO;
          res_pend_d = 1'b0;
          vid_d      = VEC_RES;
          base_d     = BASE_RES;
        end else if (boundary) begin
          if (nmi_eff) begin
            state_d    = FETCH_LO;
            nmi_pend_d = 1'b0;
            vid_d      = VEC_NMI;
            base_d     = BASE_NMI;
          end else if (brk_pend_q) begin
            // A fresh brk_req in this very cycle stays pending for a later service.
            state_d    = FETCH_LO;
            brk_pend_d = brk_req;
            vid_d      = VEC_IRQ;
            base_d     = BASE_IRQ;
          end else if (irq_act) begin
            state_d = FETCH_LO;
            vid_d   = VEC_IRQ;
            base_d  = BASE_IRQ;
          end
        end
      end
      FETCH_LO: begin
        if (mem_ready) begin
          lo_d    = mem_data;
          state_d = FETCH_HI;
        end
      end
      FETCH_HI: begin
        if (mem_ready) begin
          hi_d    = mem_data;
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        pcl_d   = lo_q;
        pch_d   = hi_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef VECFETCH_TIMEOUT_EN
    wait_d  = 8'd0;
    fault_d = fault_q;
    if (fetching && !mem_ready) begin
      if (wait_q == WAIT_LAST) begin
        state_d = IDLE;
        fault_d = 1'b1;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin : state_reg
    if (!rst_n) begin
      state_q    <= IDLE;
      res_pend_q <= 1'b1;
      nmi_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      nmi_q      <= 1'b1;
      base_q     <= 16'h0000;
      vid_q      <= VEC_RES;
      lo_q       <= 8'h00;
      hi_q       <= 8'h00;
      pcl_q      <= 8'h00;
      pch_q      <= 8'h00;
`ifdef VECFETCH_TIMEOUT_EN
      wait_q     <= 8'd0;
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      res_pend_q <= res_pend_d;
      nmi_pend_q <= nmi_pend_d;
      brk_pend_q <= brk_pend_d;
      nmi_q      <= nmi_n;
      base_q     <= base_d;
      vid_q      <= vid_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      pcl_q      <= pcl_d;
      pch_q      <= pch_d;
`ifdef VECFETCH_TIMEOUT_EN
      wait_q     <= wait_d;
      fault_q    <= fault_d;
`endif
    end
  end

  always_comb begin : outputs
    mem_rd    = fetching;
    mem_addr  = 16'h0000;
    load_pc_l = 1'b0;
    load_pc_h = 1'b0;
    done      = 1'b0;
    PCL_in    = pcl_q;
    PCH_in    = pch_q;
    unique case (state_q)
      FETCH_LO: mem_addr = base_q;
      FETCH_HI: mem_addr = base_q + 16'd1;
      COMMIT: begin
        load_pc_l = 1'b1;
        load_pc_h = 1'b1;
        done      = 1'b1;
        PCL_in    = lo_q;
        PCH_in    = hi_q;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign vector_id = vid_q;
`ifdef VECFETCH_TIMEOUT_EN
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule
